// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

  localparam logic [3:0]  BIOS_REGION = 4'h4;
  localparam logic [3:0]  IMEM_REGION = 4'h1;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;

  typedef enum logic [1:0] {
    SRC_BIOS,
    SRC_IMEM,
    SRC_FAULT
  } fetch_src_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/if_mem_sel.sv
// Region decode of a fetch PC and selection of the matching BRAM read data.
module if_mem_sel
  import if_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INST
) (
  input  logic [3:0]  region,
  input  logic [1:0]  align,
  input  fetch_src_t  src_sel,
  input  logic [31:0] bios_dout,
  input  logic [31:0] imem_dout,
  output fetch_src_t  src,
  output logic [31:0] inst
);

  // Map the PC region to a source; misaligned or unmapped PCs fault.
  always_comb begin
    src = SRC_FAULT;
    if (align == 2'b00) begin
      if (region == BIOS_REGION) begin
        src = SRC_BIOS;
      end else if (region == IMEM_REGION) begin
        src = SRC_IMEM;
      end
    end
  end

  // Pick the read data of the source registered with the in-flight fetch.
  always_comb begin
    inst = NOP;
    case (src_sel)
      SRC_BIOS: inst = bios_dout;
      SRC_IMEM: inst = imem_dout;
      default:  inst = NOP;
    endcase
  end

endmodule

// File: rtl/if_fetch_buf.sv
// IF stage: issues BRAM reads for pc, aligns returned words with their PC,
// and handles stall replay, flush bubbles and fetch faults.
module if_fetch_buf
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP      = NOP_INST,
  parameter int          BIOS_AW  = 12,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  input  logic               stall,
  input  logic               flush,
  output logic [BIOS_AW-1:0] bios_addr,
  input  logic [31:0]        bios_dout,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_dout,
  output logic [31:0]        inst_d,
  output logic [31:0]        pc_d,
  output logic               valid_d,
  output logic               fault_d
);

  fetch_state_t state_q;
  fetch_src_t   src_q;
  fetch_src_t   dec_src;
  logic [31:0]  pc_q;
  logic [31:0]  mux_inst;
  logic         kill_q;
  logic [31:0]  hold_inst_q;
  logic [31:0]  hold_pc_q;
  logic         hold_fault_q;
  logic         capture;
  logic         unused_pc;

  assign bios_addr = pc[BIOS_AW+1:2];
  assign imem_addr = pc[IMEM_AW+1:2];
  assign unused_pc = ^pc;

  // The in-flight fetch is replaced unless decode is stalling; a redirect or
  // the boot cycle always takes the new PC so the pipeline restarts cleanly.
  assign capture = !stall || flush || (state_q == BOOT);

  if_mem_sel #(
    .NOP(NOP)
  ) u_mem_sel (
    .region   (pc[31:28]),
    .align    (pc[1:0]),
    .src_sel  (src_q),
    .bios_dout(bios_dout),
    .imem_dout(imem_dout),
    .src      (dec_src),
    .inst     (mux_inst)
  );

  // Remember where the outstanding BRAM read came from and for which PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= SRC_FAULT;
      pc_q  <= RESET_PC;
    end else if (capture) begin
      src_q <= dec_src;
      pc_q  <= pc;
    end
  end

  // Fetch control: boot bubble, normal run, stall replay and flush kill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      kill_q       <= 1'b0;
      hold_inst_q  <= NOP;
      hold_pc_q    <= RESET_PC;
      hold_fault_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          kill_q  <= flush;
        end
        RUN: begin
          if (flush) begin
            kill_q       <= 1'b1;
            hold_inst_q  <= NOP;
            hold_fault_q <= 1'b0;
          end else if (stall && !kill_q) begin
            state_q      <= HOLD;
            hold_inst_q  <= mux_inst;
            hold_pc_q    <= pc_q;
            hold_fault_q <= (src_q == SRC_FAULT);
          end else if (!stall) begin
            kill_q <= 1'b0;
          end
        end
        HOLD: begin
          if (flush) begin
            state_q      <= RUN;
            kill_q       <= 1'b1;
            hold_inst_q  <= NOP;
            hold_fault_q <= 1'b0;
          end else if (!stall) begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= BOOT;
          kill_q  <= 1'b0;
        end
      endcase
    end
  end

  // Drive the IF/ID outputs from the live BRAM word or the hold register.
  always_comb begin
    inst_d  = NOP;
    pc_d    = pc_q;
    valid_d = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      BOOT: begin
        pc_d = RESET_PC;
      end
      RUN: begin
        if (!kill_q) begin
          inst_d  = mux_inst;
          valid_d = 1'b1;
          fault_d = (src_q == SRC_FAULT);
        end
      end
      HOLD: begin
        inst_d  = hold_inst_q;
        pc_d    = hold_pc_q;
        valid_d = 1'b1;
        fault_d = hold_fault_q;
      end
      default: begin
        pc_d = RESET_PC;
      end
    endcase
  end

endmodule
